// File: rtl/sd4_mac_pkg.sv
// rtl/sd4_mac_pkg.sv - SD4 MAC operand packer constants and FSM state type
package sd4_mac_pkg;
  localparam int LANES = 9;
  localparam int IMG_W = 8;
  localparam int WGT_W = 4;
  localparam int EXP_W = 5;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_t;
endpackage

// File: rtl/mac_pack_lane_cnt.sv
// rtl/mac_pack_lane_cnt.sv - lane index counter for the operand packer
// clr wins over load-1, load-1 wins over increment.
module mac_pack_lane_cnt
  import sd4_mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load1,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic             is_last
);
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (load1) begin
      idx_d = IDX_W'(1);
    end else if (inc) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx     = idx_q;
  assign is_last = (idx_q == LAST_IDX);
endmodule

// File: rtl/mac_operand_packer.sv
// rtl/mac_operand_packer.sv - packs serial (image, weight) beats into one MAC frame
// Optional MAC_PACK_RESYNC_CNT_EN adds the saturating framing-error counter port resync_cnt.
module mac_operand_packer
  import sd4_mac_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic [IMG_W-1:0]       in_image,
  input  logic [WGT_W-1:0]       in_weight,
  input  logic [EXP_W-1:0]       in_exp_bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*IMG_W-1:0] image_out,
  output logic [LANES*WGT_W-1:0] weight_out,
  output logic [EXP_W-1:0]       exp_bias_out
`ifdef MAC_PACK_RESYNC_CNT_EN
  ,
  output logic [7:0]             resync_cnt
`endif
);
  pack_state_t state_q, state_d;
  // Element [LANES-1] holds lane 0 so the packed vectors put lane 0 in the MSBs.
  logic [LANES-1:0][IMG_W-1:0] img_buf_q, img_buf_d;
  logic [LANES-1:0][WGT_W-1:0] wgt_buf_q, wgt_buf_d;
  logic [EXP_W-1:0]            bias_buf_q, bias_buf_d;
  logic [LANES-1:0][IMG_W-1:0] image_out_q, image_out_d;
  logic [LANES-1:0][WGT_W-1:0] weight_out_q, weight_out_d;
  logic [EXP_W-1:0]            exp_bias_out_q, exp_bias_out_d;
  logic                        out_valid_q, out_valid_d;

  logic             accept;
  logic             load1, inc, clr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] lane_pos;
  logic             is_last;

  mac_pack_lane_cnt u_lane_cnt (
    .clk     (clk),
    .rst     (rst),
    .load1   (load1),
    .inc     (inc),
    .clr     (clr),
    .idx     (idx),
    .is_last (is_last)
  );

  // Only the completing beat can stall, and only behind an undrained frame.
  assign in_ready = rst && !(is_last && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign lane_pos = LAST_IDX - idx;

  always_comb begin
    state_d        = state_q;
    img_buf_d      = img_buf_q;
    wgt_buf_d      = wgt_buf_q;
    bias_buf_d     = bias_buf_q;
    image_out_d    = image_out_q;
    weight_out_d   = weight_out_q;
    exp_bias_out_d = exp_bias_out_q;
    out_valid_d    = out_valid_q && !out_ready;
    load1          = 1'b0;
    inc            = 1'b0;
    clr            = 1'b0;
    if (accept) begin
      if (in_first) begin
        img_buf_d[LANES-1] = in_image;
        wgt_buf_d[LANES-1] = in_weight;
        bias_buf_d         = in_exp_bias;
        load1              = 1'b1;
        state_d            = FILL;
      end else if (state_q == FILL) begin
        if (is_last) begin
          image_out_d     = img_buf_q;
          image_out_d[0]  = in_image;
          weight_out_d    = wgt_buf_q;
          weight_out_d[0] = in_weight;
          exp_bias_out_d  = bias_buf_q;
          out_valid_d     = 1'b1;
          clr             = 1'b1;
          state_d         = IDLE;
        end else begin
          img_buf_d[lane_pos] = in_image;
          wgt_buf_d[lane_pos] = in_weight;
          inc                 = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      img_buf_q      <= '0;
      wgt_buf_q      <= '0;
      bias_buf_q     <= '0;
      image_out_q    <= '0;
      weight_out_q   <= '0;
      exp_bias_out_q <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      img_buf_q      <= img_buf_d;
      wgt_buf_q      <= wgt_buf_d;
      bias_buf_q     <= bias_buf_d;
      image_out_q    <= image_out_d;
      weight_out_q   <= weight_out_d;
      exp_bias_out_q <= exp_bias_out_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign image_out    = image_out_q;
  assign weight_out   = weight_out_q;
  assign exp_bias_out = exp_bias_out_q;

`ifdef MAC_PACK_RESYNC_CNT_EN
  logic [7:0] resync_q, resync_d;
  logic       frame_err;

  assign frame_err = accept && (in_first ? (state_q == FILL) : (state_q == IDLE));

  always_comb begin
    resync_d = resync_q;
    if (frame_err && resync_q != 8'hFF) begin
      resync_d = resync_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resync_q <= '0;
    end else begin
      resync_q <= resync_d;
    end
  end

  assign resync_cnt = resync_q;
`endif
endmodule

// File: tb/tb_mac_operand_packer.sv
// tb/tb_mac_operand_packer.sv - scoreboard bench for mac_operand_packer
// Define MAC_PACK_RESYNC_CNT_EN to also check resync_cnt.
module tb_mac_operand_packer;
  import sd4_mac_pkg::*;

  typedef struct {
    logic [71:0] img;
    logic [35:0] wgt;
    logic [4:0]  bias;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_first = 1'b0;
  logic [7:0]  in_image = '0;
  logic [3:0]  in_weight = '0;
  logic [4:0]  in_exp_bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] image_out;
  logic [35:0] weight_out;
  logic [4:0]  exp_bias_out;
`ifdef MAC_PACK_RESYNC_CNT_EN
  logic [7:0]  resync_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  int stall_cnt = 0;
  frame_t exp_q[$];

  logic [71:0] m_img;
  logic [35:0] m_wgt;
  logic [4:0]  m_bias;
  int          m_idx = 0;
  bit          m_fill = 1'b0;

  bit          held = 1'b0;
  logic [127:0] snap;

  always #5 clk = ~clk;

  mac_operand_packer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_first     (in_first),
    .in_image     (in_image),
    .in_weight    (in_weight),
    .in_exp_bias  (in_exp_bias),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .image_out    (image_out),
    .weight_out   (weight_out),
    .exp_bias_out (exp_bias_out)
`ifdef MAC_PACK_RESYNC_CNT_EN
    ,
    .resync_cnt   (resync_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks holding stability.
  always @(negedge clk) begin
    if (!rst || !out_valid) begin
      held = 1'b0;
    end else if (out_ready) begin
      held = 1'b0;
      chk("frame_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        frame_t f;
        f = exp_q.pop_front();
        chk("image_out", 128'(image_out), 128'(f.img));
        chk("weight_out", 128'(weight_out), 128'(f.wgt));
        chk("exp_bias_out", 128'(exp_bias_out), 128'(f.bias));
      end
      out_cnt++;
    end else begin
      if (held) chk("hold_stable", 128'({image_out, weight_out, exp_bias_out}), snap);
      snap = 128'({image_out, weight_out, exp_bias_out});
      held = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
  task automatic send_beat(input bit first, input logic [7:0] img, input logic [3:0] w,
                           input logic [4:0] b);
    int tries = 0;
    in_valid = 1'b1; in_first = first; in_image = img; in_weight = w; in_exp_bias = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stall_cnt++;
      tries++;
      if (tries > 20) begin
        chk("beat_accept_timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (first) begin
      m_img = {64'b0, img}; m_wgt = {32'b0, w}; m_bias = b; m_idx = 1; m_fill = 1'b1;
    end else if (m_fill) begin
      m_img = {m_img[63:0], img};
      m_wgt = {m_wgt[31:0], w};
      if (m_idx == 8) begin
        exp_q.push_back('{img: m_img, wgt: m_wgt, bias: m_bias});
        m_fill = 1'b0; m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] ib, input logic [3:0] wb, input logic [4:0] b);
    for (int i = 0; i < 9; i++) send_beat(i == 0, ib + 8'(i), wb + 4'(i), b);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_first = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int oc;
    // Power-on reset state
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_image_out", 128'(image_out), 128'(0));
    @(posedge clk); #1; rst = 1'b1;
    idle(1);

    // IDLE garbage
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(1'b0, 8'hA0 + 8'(i), 4'(i), 5'd3);
    idle(3);
    chk("garbage_no_output", 128'(out_cnt), 128'(0));
    chk("garbage_out_valid", 128'(out_valid), 128'(0));
`ifdef MAC_PACK_RESYNC_CNT_EN
    chk("garbage_resync_cnt", 128'(resync_cnt), 128'(3));
`endif

    // Single frame with constant expectations
    for (int i = 0; i < 8; i++) send_beat(i == 0, 8'h10 + 8'(i), 4'(i), 5'b11110);
    chk("single_no_early_valid", 128'(out_valid), 128'(0));
    send_beat(1'b0, 8'h18, 4'd8, 5'b11110);
    chk("single_latency", 128'(out_valid), 128'(1));
    chk("single_image", 128'(image_out), 128'(72'h101112131415161718));
    chk("single_weight", 128'(weight_out), 128'(36'h012345678));
    chk("single_bias", 128'(exp_bias_out), 128'(5'b11110));
    idle(2);
    chk("single_count", 128'(out_cnt), 128'(1));

    // Back-pressure
    out_ready = 1'b0;
    send_frame(8'h20, 4'h1, 5'd7);
    for (int i = 0; i < 8; i++) send_beat(i == 0, 8'h40 + 8'(i), 4'h5 + 4'(i), 5'd9);
    in_valid = 1'b1; in_first = 1'b0; in_image = 8'h48; in_weight = 4'hD; in_exp_bias = 5'd9;
    repeat (3) begin
      @(negedge clk);
      chk("bp_lane8_stall", 128'(in_ready), 128'(0));
      chk("bp_held_image", 128'(image_out), 128'(72'h202122232425262728));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_beat(1'b0, 8'h48, 4'hD, 5'd9);
    idle(3);
    chk("bp_both_delivered", 128'(out_cnt), 128'(3));
    chk("bp_queue_empty", 128'(exp_q.size()), 128'(0));

    // Back-to-back streaming
    stall_cnt = 0;
    oc = out_cnt;
    for (int f = 0; f < 4; f++) send_frame(8'h60 + 8'(f * 16), 4'(f * 3), 5'(f + 1));
    idle(3);
    chk("stream_no_stall", 128'(stall_cnt), 128'(0));
    chk("stream_count", 128'(out_cnt - oc), 128'(4));

    // Resync at lane 5
    oc = out_cnt;
    for (int i = 0; i < 5; i++) send_beat(i == 0, 8'hC0 + 8'(i), 4'(i), 5'd2);
    send_frame(8'hD0, 4'h7, 5'd17);
    idle(3);
    chk("resync_count", 128'(out_cnt - oc), 128'(1));
    chk("resync_queue_empty", 128'(exp_q.size()), 128'(0));
`ifdef MAC_PACK_RESYNC_CNT_EN
    chk("resync_cnt", 128'(resync_cnt), 128'(4));
`endif

    // Async reset mid-frame with a held output frame
    out_ready = 1'b0;
    send_frame(8'h80, 4'h2, 5'd11);
    for (int i = 0; i < 4; i++) send_beat(i == 0, 8'hE0 + 8'(i), 4'(i), 5'd5);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
    chk("mid_rst_outputs", 128'({image_out, weight_out, exp_bias_out}), 128'(0));
`ifdef MAC_PACK_RESYNC_CNT_EN
    chk("mid_rst_resync_cnt", 128'(resync_cnt), 128'(0));
`endif
    exp_q.delete(); m_fill = 1'b0; m_idx = 0;
    @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1;
    oc = out_cnt;
    for (int i = 0; i < 9; i++) send_beat(i == 0, 8'h30 + 8'(i), 4'(8 - i), 5'd21);
    chk("post_rst_image", 128'(image_out), 128'(72'h303132333435363738));
    chk("post_rst_weight", 128'(weight_out), 128'(36'h876543210));
    idle(3);
    chk("post_rst_count", 128'(out_cnt - oc), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
